// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - writable control store with micro-PC sequencing and registered control word
// Words are {ctrl, seq, csel, target}; the word at upc issues on the next unstalled edge.

module microcode_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CTRL_W = 16,
    parameter int OP_W   = 4,
    parameter int COND_W = 4,
    parameter logic [ADDR_W-1:0] DISPATCH_BASE = ADDR_W'('h80),
    localparam int CSEL_W = (COND_W > 1) ? $clog2(COND_W) : 1,
    localparam int WORD_W = CTRL_W + 3 + CSEL_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              start,
    input  logic              stall,
    input  logic [OP_W-1:0]   opcode,
    input  logic [COND_W-1:0] cond,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              ctrl_valid,
    output logic [ADDR_W-1:0] upc,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'b000,
        SEQ_JUMP     = 3'b001,
        SEQ_BR_T     = 3'b010,
        SEQ_BR_F     = 3'b011,
        SEQ_DISPATCH = 3'b100,
        SEQ_END      = 3'b101
    } seq_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [CTRL_W-1:0] ctrl_word_q, ctrl_word_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] store_q [DEPTH];
    logic              store_we;

    logic [WORD_W-1:0] word;
    logic [CTRL_W-1:0] word_ctrl;
    logic [2:0]        word_seq;
    logic [CSEL_W-1:0] word_csel;
    logic [ADDR_W-1:0] word_target;
    logic [ADDR_W-1:0] upc_plus1;
    logic [ADDR_W-1:0] dispatch_addr;
    logic              cond_bit;

    // Writes only land while idle, so a running program never sees its store change.
    assign store_we = prog_we && !rst && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (store_we) begin
            store_q[prog_addr] <= prog_data;
        end
    end

    assign word        = store_q[upc_q];
    assign word_ctrl   = word[WORD_W-1 -: CTRL_W];
    assign word_seq    = word[ADDR_W+CSEL_W +: 3];
    assign word_csel   = word[ADDR_W +: CSEL_W];
    assign word_target = word[ADDR_W-1:0];

    assign upc_plus1     = upc_q + ADDR_W'(1);
    assign dispatch_addr = DISPATCH_BASE + ADDR_W'(opcode);

    // Out-of-range selects fall back to condition 0.
    always_comb begin
        cond_bit = cond[0];
        for (int i = 0; i < COND_W; i++) begin
            if (word_csel == CSEL_W'(i)) begin
                cond_bit = cond[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        upc_d        = upc_q;
        ctrl_word_d  = ctrl_word_q;
        ctrl_valid_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                upc_d       = '0;
                ctrl_word_d = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!stall) begin
                    ctrl_word_d  = word_ctrl;
                    ctrl_valid_d = 1'b1;
                    case (word_seq)
                        SEQ_JUMP:     upc_d = word_target;
                        SEQ_BR_T:     upc_d = cond_bit ? word_target : upc_plus1;
                        SEQ_BR_F:     upc_d = cond_bit ? upc_plus1 : word_target;
                        SEQ_DISPATCH: upc_d = dispatch_addr;
                        SEQ_END: begin
                            upc_d   = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        default:      upc_d = upc_plus1;
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
                upc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            upc_q        <= '0;
            ctrl_word_q  <= '0;
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            upc_q        <= upc_d;
            ctrl_word_q  <= ctrl_word_d;
            ctrl_valid_q <= ctrl_valid_d;
            done_q       <= done_d;
        end
    end

    assign ctrl_word  = ctrl_word_q;
    assign ctrl_valid = ctrl_valid_q;
    assign upc        = upc_q;
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - self-checking bench for microcode_sequencer against a program-walking model
// The model walks the program as an array of words and tracks the issue stream cycle by cycle.

module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [28:0] prog_data;
    logic        start;
    logic        stall;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic [15:0] ctrl_word;
    logic        ctrl_valid;
    logic [7:0]  upc;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .stall      (stall),
        .opcode     (opcode),
        .cond       (cond),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .upc        (upc),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [28:0] mem [256];
    bit          m_run;
    int          m_pc;
    int          m_ctrl;
    bit          m_valid;
    bit          m_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [28:0] mk(input int ctrl, input int seq, input int csel, input int tgt);
        return {16'(ctrl), 3'(seq), 2'(csel), 8'(tgt)};
    endfunction

    // One clock of the reference: take the word at the model PC and decide what issues.
    task automatic model_step();
        int w, seq, csel, tgt;
        m_done = 0;
        m_valid = 0;
        if (rst) begin
            m_run = 0; m_pc = 0; m_ctrl = 0;
        end else if (!m_run) begin
            if (prog_we) mem[prog_addr] = prog_data;
            m_pc = 0; m_ctrl = 0;
            if (start) m_run = 1;
        end else if (!stall) begin
            w    = int'(mem[m_pc]);
            m_ctrl = (w >> 13) & 16'hFFFF;
            seq  = (w >> 10) & 7;
            csel = (w >> 8) & 3;
            tgt  = w & 8'hFF;
            m_valid = 1;
            case (seq)
                1: m_pc = tgt;
                2: m_pc = cond[csel] ? tgt : (m_pc + 1) % 256;
                3: m_pc = !cond[csel] ? tgt : (m_pc + 1) % 256;
                4: m_pc = (8'h80 + opcode) % 256;
                5: begin m_done = 1; m_run = 0; m_pc = 0; end
                default: m_pc = (m_pc + 1) % 256;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ctrl_word", 32'(ctrl_word), 32'(m_ctrl));
        check_eq("ctrl_valid", 32'(ctrl_valid), 32'(m_valid));
        check_eq("upc", 32'(upc), 32'(m_pc));
        check_eq("busy", 32'(busy), 32'(m_run));
        check_eq("done", 32'(done), 32'(m_done));
    endtask

    task automatic prog(input int addr, input logic [28:0] data);
        prog_we = 1'b1;
        prog_addr = 8'(addr);
        prog_data = data;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && m_run; i++) tick();
        check_eq("run_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; stall = 1'b0; opcode = '0; cond = '0;
        m_run = 0; m_pc = 0; m_ctrl = 0; m_valid = 0; m_done = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        tick();
        tick();
        check_eq("rst_ctrl", 32'(ctrl_word), 32'd0);
        check_eq("rst_valid", 32'(ctrl_valid), 32'd0);
        check_eq("rst_upc", 32'(upc), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int a = 0; a < 256; a++) prog(a, 29'($urandom));

        // Sequential NEXT then END.
        prog(0, mk(16'h0001, 0, 0, 0));
        prog(1, mk(16'h0002, 5, 0, 0));
        kick();
        tick();
        check_eq("seq_w0", 32'(ctrl_word), 32'h0001);
        check_eq("seq_w0_valid", 32'(ctrl_valid), 32'd1);
        tick();
        check_eq("seq_w1", 32'(ctrl_word), 32'h0002);
        check_eq("seq_done", 32'(done), 32'd1);
        tick();
        check_eq("seq_end_busy", 32'(busy), 32'd0);
        check_eq("seq_end_upc", 32'(upc), 32'd0);
        check_eq("seq_end_ctrl", 32'(ctrl_word), 32'd0);

        // Conditional branch taken and not taken.
        prog(0, mk(16'h0010, 2, 2, 8'h20));
        prog(8'h20, mk(16'h0020, 5, 0, 0));
        prog(1, mk(16'h0111, 5, 0, 0));
        cond = 4'b0100;
        kick();
        tick();
        check_eq("brt_w0", 32'(ctrl_word), 32'h0010);
        tick();
        check_eq("brt_taken", 32'(ctrl_word), 32'h0020);
        tick();
        cond = 4'b0000;
        kick();
        tick();
        check_eq("brt_w0b", 32'(ctrl_word), 32'h0010);
        tick();
        check_eq("brt_not_taken", 32'(ctrl_word), 32'h0111);
        tick();

        // Opcode dispatch.
        prog(0, mk(16'h00AA, 4, 0, 0));
        prog(8'h85, mk(16'h0085, 5, 0, 0));
        opcode = 4'd5;
        kick();
        tick();
        check_eq("disp_upc", 32'(upc), 32'h85);
        check_eq("disp_w0", 32'(ctrl_word), 32'h00AA);
        tick();
        check_eq("disp_w1", 32'(ctrl_word), 32'h0085);
        check_eq("disp_done", 32'(done), 32'd1);
        tick();

        // Wrap past 0xFF, stall, write protection and mid-run reset.
        prog(0, mk(16'h0123, 1, 0, 8'hFF));
        prog(8'hFF, mk(16'h0FFF, 0, 0, 0));
        prog(1, mk(16'h0111, 0, 0, 0));
        prog(2, mk(16'h0222, 5, 0, 0));
        kick();
        tick();
        tick();
        check_eq("wrap_upc", 32'(upc), 32'd0);
        check_eq("wrap_ctrl", 32'(ctrl_word), 32'h0FFF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid", 32'(ctrl_valid), 32'd0);
            check_eq("stall_upc", 32'(upc), 32'd0);
            check_eq("stall_ctrl", 32'(ctrl_word), 32'h0FFF);
        end
        stall = 1'b0;
        tick();
        check_eq("resume_ctrl", 32'(ctrl_word), 32'h0123);
        check_eq("resume_upc", 32'(upc), 32'hFF);
        prog(1, mk(16'hDEAD, 5, 0, 0));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_ctrl", 32'(ctrl_word), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        prog(0, mk(16'h0100, 0, 0, 0));
        kick();
        tick();
        check_eq("prot_w0", 32'(ctrl_word), 32'h0100);
        tick();
        check_eq("prot_w1", 32'(ctrl_word), 32'h0111);
        tick();
        check_eq("prot_w2", 32'(ctrl_word), 32'h0222);
        run_idle(4);

        // Randomised traffic over the whole interface.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 3) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            prog_we   = ($urandom_range(0, 5) == 0);
            prog_addr = 8'($urandom);
            prog_data = 29'($urandom);
            opcode    = 4'($urandom);
            cond      = 4'($urandom);
            tick();
        end
        rst = 1'b0; start = 1'b0; stall = 1'b0; prog_we = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Writable, parametrised control store with its own micro-program counter (uPC), next-address logic and registered control-word output.
- Next generation of the fixed combinational control ROM. Adds programmable contents, sequencing (next, jump, conditional branch, opcode dispatch, end) and a stall handshake.
- Sits between instruction decode (opcode, condition flags) and the datapath, which consumes ctrl_word.

Parameters:
- ADDR_W, 8, uPC / store address width; depth = 2**ADDR_W.
- CTRL_W, 16, control-word width driven to the datapath.
- OP_W, 4, opcode width used for dispatch.
- COND_W, 4, number of condition inputs; CSEL_W = clog2(COND_W), minimum 1.
- DISPATCH_BASE, 8'h80, base store address for opcode dispatch, ADDR_W bits.
- Derived: WORD_W = CTRL_W + 3 + CSEL_W + ADDR_W (29 with the defaults).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  control-store write strobe.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  WORD_W  write data, laid out {ctrl, seq[2:0], csel, target}, MSB first.
- start  in  1  begin execution at uPC 0.
- stall  in  1  datapath not ready; freeze the sequencer.
- opcode  in  OP_W  dispatch index.
- cond  in  COND_W  branch condition flags.
- ctrl_word  out  CTRL_W  registered control word.
- ctrl_valid  out  1  ctrl_word is new this cycle.
- upc  out  ADDR_W  current micro-PC.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the END word issues.

Behaviour:
- Reset: state IDLE; upc=0, ctrl_word=0, ctrl_valid=0, busy=0, done=0. Control-store contents are not reset.
- Control store read: asynchronous/combinational from address upc. Outputs are registered, so a word at address a appears on ctrl_word one edge after upc==a.
- Control store write:
  - Accepted only in IDLE; prog_we in RUN is ignored.
  - Write takes effect at the edge, so a read of the same address on the next cycle returns the new data.
- States:
  - IDLE: ctrl_word=0, ctrl_valid=0, upc held at 0. start=1 -> RUN next cycle, busy=1.
  - RUN with stall=1: upc, ctrl_word and state held; ctrl_valid=0; done=0.
  - RUN with stall=0: at the edge, ctrl_word<=store[upc].ctrl, ctrl_valid<=1, upc<=next.
- next by seq field:
  - 000 NEXT: upc+1, modulo 2**ADDR_W, so address max wraps to 0.
  - 001 JUMP: target.
  - 010 BR_T: cond[csel] ? target : upc+1.
  - 011 BR_F: !cond[csel] ? target : upc+1.
  - 100 DISPATCH: (DISPATCH_BASE + opcode) mod 2**ADDR_W, opcode zero-extended.
  - 101 END: ctrl emitted with ctrl_valid=1, done=1 for one cycle, busy<=0, upc<=0, state<=IDLE.
  - 110, 111: treated as NEXT.
- csel >= COND_W selects condition 0.
- Condition and opcode inputs are sampled in the same cycle as the word that uses them.
- start in RUN is ignored.
- start and prog_we together in IDLE: both are accepted; the first RUN cycle reads post-write contents.
- Reset mid-RUN: the reset values above apply at that edge. done does not pulse.
- stall in IDLE has no effect. stall in the END cycle delays the END; done pulses only on the unstalled cycle.

Test Plan:
- Sequential run with END: program addr0={ctrl 0x0001, NEXT}, addr1={0x0002, END}; start at cycle 0.
  - Expect ctrl_word=0x0001, ctrl_valid=1 after edge 2.
  - Expect ctrl_word=0x0002, done=1 after edge 3.
  - Expect busy=0, upc=0, ctrl_word=0 after edge 4.
- Branch: addr0={0x0010, BR_T, csel=2, target=0x20}, addr0x20={0x0020, END}.
  - cond=4'b0100: ctrl sequence is 0x0010 then 0x0020.
  - cond=4'b0000: ctrl sequence is 0x0010 then store[1].
- Dispatch: addr0={0x00AA, DISPATCH}, opcode=5, addr0x85={0x0085, END}.
  - Expect upc=0x85 after the first word; ctrl sequence 0x00AA, 0x0085; done pulses.
- Stall and wrap:
  - Program addr0={JUMP, target 0xFF} and addr0xFF={0x0FFF, NEXT}.
  - Expect upc to wrap to 0 after 0xFF issues.
  - Hold stall 3 cycles mid-run: upc and ctrl_word frozen, ctrl_valid=0 for those 3 cycles, then resume with no word skipped or repeated.
- Protection and reset:
  - prog_we to addr1 during RUN: contents unchanged, verified after the next start.
  - rst asserted mid-RUN: next cycle all outputs are 0 and state is IDLE; a later start runs from uPC 0 with contents intact.
